regfile_mp_scb: RTL and testbench

//  Parametrised multi-read-port integer register file with an integrated busy-bit scoreboard.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 62 ++++++
 rtl/regfile_mp_scb.sv | 80 ++++++++
 tb/tb_regfile_mp_scb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, data type and x0 helper for the register file slice
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [XLEN_DEF-1:0] rf_data_t;

  // Callers widen their address to 32 bits so one helper serves every AW.
  function automatic logic rf_zero(input logic [31:0] addr);
    return addr == 32'd0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy-bit scoreboard: flush > set > clear, registered busy count
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NRD*AW-1:0] i_rs_addr,
  output logic [NRD-1:0]    o_rs_busy,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_rd,
  output logic              o_iss_ready,
  input  logic              i_rd_wren,
  input  logic [AW-1:0]     i_rd_addr,
  input  logic              i_flush,
  output logic [AW:0]       o_busy_cnt
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            set_w, clr_w, clr_eff;

  // busy_q[0] is never set, so x0 always reads as ready and not busy.
  assign o_iss_ready = !busy_q[i_iss_rd];
  assign set_w       = i_iss_valid && o_iss_ready && !rf_zero(32'(i_iss_rd));
  assign clr_w       = i_rd_wren && !rf_zero(32'(i_rd_addr));
  // A set only fires on a non-busy register, so a same-register clear never decrements.
  assign clr_eff     = clr_w && busy_q[i_rd_addr];

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (i_flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (clr_w) busy_d[i_rd_addr] = 1'b0;
      if (set_w) busy_d[i_iss_rd]  = 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, set_w} - {{AW{1'b0}}, clr_eff};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_lookup
    assign o_rs_busy[k] = busy_q[i_rs_addr[k*AW +: AW]];
  end

  assign o_busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_scb.sv
// rtl/regfile_mp_scb.sv - multi-read-port register file with busy scoreboard
// REGFILE_BYPASS_EN: forward same-cycle writeback data to matching read ports.
module regfile_mp_scb
  import rf_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic                i_rd_wren,
  input  logic [AW-1:0]       i_rd_addr,
  input  logic [XLEN-1:0]     i_rd_data,
  input  logic                i_iss_valid,
  input  logic [AW-1:0]       i_iss_rd,
  output logic                o_iss_ready,
  input  logic                i_flush,
  output logic [AW:0]         o_busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NRD-1:0]  sb_busy;
  logic            wr_en;

  assign wr_en = i_rd_wren && !rf_zero(32'(i_rd_addr));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[i_rd_addr] <= i_rd_data;
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NRD  (NRD)
  ) u_sb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rs_addr   (i_rs_addr),
    .o_rs_busy   (sb_busy),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .o_iss_ready (o_iss_ready),
    .i_rd_wren   (i_rd_wren),
    .i_rd_addr   (i_rd_addr),
    .i_flush     (i_flush),
    .o_busy_cnt  (o_busy_cnt)
  );

`ifdef REGFILE_BYPASS_EN
  logic iss_set;
  assign iss_set = i_iss_valid && o_iss_ready && !i_flush && !rf_zero(32'(i_iss_rd));
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr_k;
    logic [XLEN-1:0] stored_k;
    assign addr_k   = i_rs_addr[k*AW +: AW];
    assign stored_k = rf_zero(32'(addr_k)) ? '0 : regs_q[addr_k];
`ifdef REGFILE_BYPASS_EN
    // A forwarded operand is ready now, unless this cycle's issue claims it again.
    logic byp_k;
    assign byp_k = wr_en && (addr_k == i_rd_addr);
    assign o_rs_data[k*XLEN +: XLEN] = byp_k ? i_rd_data : stored_k;
    assign o_rs_busy[k] = byp_k ? (iss_set && (i_iss_rd == addr_k)) : sb_busy[k];
`else
    assign o_rs_data[k*XLEN +: XLEN] = stored_k;
    assign o_rs_busy[k] = sb_busy[k];
`endif
  end

endmodule

// File: tb/tb_regfile_mp_scb.sv
// tb/tb_regfile_mp_scb.sv - directed scoreboard-queue bench for regfile_mp_scb
module tb_regfile_mp_scb;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [9:0]  i_rs_addr;
  logic [63:0] o_rs_data;
  logic [1:0]  o_rs_busy;
  logic        i_rd_wren;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_rd_data;
  logic        i_iss_valid;
  logic [4:0]  i_iss_rd;
  logic        o_iss_ready;
  logic        i_flush;
  logic [5:0]  o_busy_cnt;

  int checks = 0;
  int errors = 0;

  typedef enum int {K_D0, K_D1, K_B0, K_B1, K_RDY, K_CNT} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  regfile_mp_scb dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rs_addr   (i_rs_addr),
    .o_rs_data   (o_rs_data),
    .o_rs_busy   (o_rs_busy),
    .i_rd_wren   (i_rd_wren),
    .i_rd_addr   (i_rd_addr),
    .i_rd_data   (i_rd_data),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .o_iss_ready (o_iss_ready),
    .i_flush     (i_flush),
    .o_busy_cnt  (o_busy_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] observe(kind_e k);
    case (k)
      K_D0:    return o_rs_data[31:0];
      K_D1:    return o_rs_data[63:32];
      K_B0:    return {31'd0, o_rs_busy[0]};
      K_B1:    return {31'd0, o_rs_busy[1]};
      K_RDY:   return {31'd0, o_iss_ready};
      default: return {26'd0, o_busy_cnt};
    endcase
  endfunction

  task automatic exp_push(input string tag, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_rd_wren   = 1'b0;
    i_iss_valid = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    i_rd_wren = 1'b1;
    i_rd_addr = a;
    i_rd_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    i_iss_valid = 1'b1;
    i_iss_rd    = a;
  endtask

  initial begin
    i_reset   = 1'b1;
    i_rs_addr = '0;
    i_rd_addr = '0;
    i_rd_data = '0;
    i_iss_rd  = '0;
    idle();
    tick();
    tick();
    i_reset = 1'b0;
    i_rs_addr = {5'd9, 5'd5};
    exp_push("por_d0", K_D0, 32'h0);
    exp_push("por_cnt", K_CNT, 32'd0);
    exp_push("por_rdy", K_RDY, 32'd1);
    drain();

    // write x5, then x0 (discarded)
    wb(5'd5, 32'hDEADBEEF);
    tick();
    wb(5'd0, 32'h00001234);
    tick();
    idle();
    i_rs_addr = {5'd0, 5'd5};
    exp_push("wr_x5", K_D0, 32'hDEADBEEF);
    exp_push("wr_x0", K_D1, 32'h0);
    exp_push("wr_b0", K_B0, 32'd0);
    drain();

    // issue x7, then write it back
    issue(5'd7);
    exp_push("iss7_rdy_before", K_RDY, 32'd1);
    drain();
    tick();
    idle();
    i_rs_addr = {5'd0, 5'd7};
    exp_push("iss7_busy", K_B0, 32'd1);
    exp_push("iss7_cnt", K_CNT, 32'd1);
    exp_push("iss7_rdy", K_RDY, 32'd0);
    drain();
    wb(5'd7, 32'h55);
    tick();
    idle();
    exp_push("wb7_busy", K_B0, 32'd0);
    exp_push("wb7_cnt", K_CNT, 32'd0);
    exp_push("wb7_data", K_D0, 32'h55);
    exp_push("wb7_rdy", K_RDY, 32'd1);
    drain();

    // set x3 and clear x7 in the same cycle
    issue(5'd7);
    tick();
    wb(5'd7, 32'h77);
    issue(5'd3);
    tick();
    idle();
    i_rs_addr = {5'd3, 5'd7};
    exp_push("sc_b7", K_B0, 32'd0);
    exp_push("sc_b3", K_B1, 32'd1);
    exp_push("sc_cnt", K_CNT, 32'd1);
    exp_push("sc_d7", K_D0, 32'h77);
    drain();
    wb(5'd3, 32'h33);
    tick();
    idle();
    exp_push("wb3_cnt", K_CNT, 32'd0);
    drain();
    // write back and issue the same non-busy register: set wins
    wb(5'd3, 32'h3A);
    issue(5'd3);
    exp_push("same_rdy", K_RDY, 32'd1);
    drain();
    tick();
    idle();
    exp_push("same_b3", K_B1, 32'd1);
    exp_push("same_cnt", K_CNT, 32'd1);
    exp_push("same_d3", K_D1, 32'h3A);
    drain();
    wb(5'd3, 32'h3B);
    tick();
    idle();

    // issue 1,2,3; re-issue busy x2 is held; then flush with issue x4
    issue(5'd1);
    tick();
    issue(5'd2);
    tick();
    issue(5'd3);
    tick();
    issue(5'd2);
    exp_push("hold_rdy", K_RDY, 32'd0);
    drain();
    tick();
    idle();
    i_rs_addr = {5'd2, 5'd1};
    exp_push("three_cnt", K_CNT, 32'd3);
    exp_push("three_b1", K_B0, 32'd1);
    exp_push("three_b2", K_B1, 32'd1);
    drain();
    i_flush = 1'b1;
    issue(5'd4);
    wb(5'd2, 32'h22);
    tick();
    idle();
    i_rs_addr = {5'd2, 5'd4};
    i_iss_rd  = 5'd4;
    exp_push("fl_b4", K_B0, 32'd0);
    exp_push("fl_b2", K_B1, 32'd0);
    exp_push("fl_cnt", K_CNT, 32'd0);
    exp_push("fl_d2", K_D1, 32'h22);
    exp_push("fl_rdy4", K_RDY, 32'd1);
    drain();

    // same-cycle write and read of x9
    i_rs_addr = {5'd0, 5'd9};
    wb(5'd9, 32'hA5A5A5A5);
`ifdef REGFILE_BYPASS_EN
    exp_push("byp_same", K_D0, 32'hA5A5A5A5);
`else
    exp_push("byp_same", K_D0, 32'h0);
`endif
    exp_push("byp_busy", K_B0, 32'd0);
    drain();
    tick();
    idle();
    exp_push("byp_next", K_D0, 32'hA5A5A5A5);
    drain();

    // mid-run asynchronous reset
    issue(5'd10);
    tick();
    idle();
    i_iss_rd  = 5'd10;
    i_rs_addr = {5'd10, 5'd9};
    exp_push("pre_rst_cnt", K_CNT, 32'd1);
    drain();
    i_reset = 1'b1;
    exp_push("rst_d0", K_D0, 32'h0);
    exp_push("rst_d1", K_D1, 32'h0);
    exp_push("rst_b0", K_B0, 32'd0);
    exp_push("rst_b1", K_B1, 32'd0);
    exp_push("rst_cnt", K_CNT, 32'd0);
    exp_push("rst_rdy", K_RDY, 32'd1);
    drain();
    tick();
    i_reset   = 1'b0;
    i_rs_addr = {5'd7, 5'd5};
    exp_push("post_rst_x5", K_D0, 32'h0);
    exp_push("post_rst_x7", K_D1, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
